// File: rtl/watch_time_reporter.sv
// Serialises a snapshot of the watch time as ASCII "HH:MM:SS.CC\r\n" (or "HH:MM:SS\r\n")
// into a TX FIFO write port, honouring FIFO back-pressure.
module watch_time_reporter #(
  parameter int unsigned MSEC_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic [6:0] i_msec,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hour,
  input  logic       i_fifo_full,
  output logic       o_push,
  output logic [7:0] o_data,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {StIdle, StConv, StSend, StDone} state_e;

  localparam logic [3:0] LastIdx = (MSEC_EN != 0) ? 4'd12 : 4'd9;

  state_e     state_q, state_d;
  logic [4:0] hour_q;
  logic [5:0] min_q, sec_q;
  logic [6:0] msec_q;
  logic [7:0] h1_q, h0_q, m1_q, m0_q, s1_q, s0_q, c1_q, c0_q;
  logic [3:0] idx_q;
  logic [6:0] msec_clamped;
  logic [7:0] frame_byte;
  logic       accept;

  function automatic logic [7:0] ascii_tens(input logic [6:0] v);
    return 8'h30 + {1'b0, v / 7'd10};
  endfunction

  function automatic logic [7:0] ascii_ones(input logic [6:0] v);
    return 8'h30 + {1'b0, v % 7'd10};
  endfunction

  assign msec_clamped = (msec_q > 7'd99) ? 7'd99 : msec_q;
  assign accept       = (state_q == StSend) && !i_fifo_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_req) state_d = StConv;
      StConv:  state_d = StSend;
      StSend:  if (accept && (idx_q == LastIdx)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Snapshot, digit conversion and byte index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hour_q <= '0;
      min_q  <= '0;
      sec_q  <= '0;
      msec_q <= '0;
      h1_q   <= '0;
      h0_q   <= '0;
      m1_q   <= '0;
      m0_q   <= '0;
      s1_q   <= '0;
      s0_q   <= '0;
      c1_q   <= '0;
      c0_q   <= '0;
      idx_q  <= '0;
    end else begin
      if ((state_q == StIdle) && i_req) begin
        hour_q <= i_hour;
        min_q  <= i_min;
        sec_q  <= i_sec;
        msec_q <= i_msec;
      end
      if (state_q == StConv) begin
        h1_q  <= ascii_tens({2'b00, hour_q});
        h0_q  <= ascii_ones({2'b00, hour_q});
        m1_q  <= ascii_tens({1'b0, min_q});
        m0_q  <= ascii_ones({1'b0, min_q});
        s1_q  <= ascii_tens({1'b0, sec_q});
        s0_q  <= ascii_ones({1'b0, sec_q});
        c1_q  <= ascii_tens(msec_clamped);
        c0_q  <= ascii_ones(msec_clamped);
        idx_q <= '0;
      end else if (accept) begin
        idx_q <= (idx_q == LastIdx) ? 4'd0 : idx_q + 4'd1;
      end
    end
  end

  always_comb begin
    frame_byte = 8'h00;
    if (MSEC_EN != 0) begin
      case (idx_q)
        4'd0:    frame_byte = h1_q;
        4'd1:    frame_byte = h0_q;
        4'd2:    frame_byte = 8'h3a;
        4'd3:    frame_byte = m1_q;
        4'd4:    frame_byte = m0_q;
        4'd5:    frame_byte = 8'h3a;
        4'd6:    frame_byte = s1_q;
        4'd7:    frame_byte = s0_q;
        4'd8:    frame_byte = 8'h2e;
        4'd9:    frame_byte = c1_q;
        4'd10:   frame_byte = c0_q;
        4'd11:   frame_byte = 8'h0d;
        4'd12:   frame_byte = 8'h0a;
        default: frame_byte = 8'h00;
      endcase
    end else begin
      case (idx_q)
        4'd0:    frame_byte = h1_q;
        4'd1:    frame_byte = h0_q;
        4'd2:    frame_byte = 8'h3a;
        4'd3:    frame_byte = m1_q;
        4'd4:    frame_byte = m0_q;
        4'd5:    frame_byte = 8'h3a;
        4'd6:    frame_byte = s1_q;
        4'd7:    frame_byte = s0_q;
        4'd8:    frame_byte = 8'h0d;
        4'd9:    frame_byte = 8'h0a;
        default: frame_byte = 8'h00;
      endcase
    end
  end

  // Outputs decode from state only, so an asynchronous reset clears them at once.
  always_comb begin
    o_push = accept;
    o_data = accept ? frame_byte : 8'h00;
    o_busy = (state_q != StIdle);
    o_done = (state_q == StDone);
  end

endmodule

// File: tb/tb_watch_time_reporter.sv
// Directed bench for watch_time_reporter: one instance with centiseconds, one without.
module tb_watch_time_reporter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req1, req0;
  logic [6:0] msec;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic       full;
  logic       push1, busy1, done1, push0, busy0, done0;
  logic [7:0] data1, data0;

  int checks = 0;
  int failures = 0;

  watch_time_reporter #(.MSEC_EN(1)) dut1 (
    .clk(clk), .rst(rst), .i_req(req1), .i_msec(msec), .i_sec(sec), .i_min(min),
    .i_hour(hour), .i_fifo_full(full), .o_push(push1), .o_data(data1), .o_busy(busy1),
    .o_done(done1)
  );

  watch_time_reporter #(.MSEC_EN(0)) dut0 (
    .clk(clk), .rst(rst), .i_req(req0), .i_msec(msec), .i_sec(sec), .i_min(min),
    .i_hour(hour), .i_fifo_full(full), .o_push(push0), .o_data(data0), .o_busy(busy0),
    .o_done(done0)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  logic [7:0] q1[$];
  logic [7:0] q0[$];
  logic [7:0] exp_q[$];
  int         done1_cnt = 0, done0_cnt = 0;
  int         req1_cyc = 0, req0_cyc = 0, done1_cyc = 0, done0_cyc = 0;
  int         bad_push = 0;

  // Capture every accepted byte and every completion pulse at the accepting edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (push1) q1.push_back(data1);
    if (push0) q0.push_back(data0);
    if (req1 && !busy1) req1_cyc <= cyc;
    if (req0 && !busy0) req0_cyc <= cyc;
    if (done1) begin
      done1_cnt <= done1_cnt + 1;
      done1_cyc <= cyc;
    end
    if (done0) begin
      done0_cnt <= done0_cnt + 1;
      done0_cyc <= cyc;
    end
    if (full && (push1 || push0)) bad_push <= bad_push + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic void build(input int h, input int m, input int s, input int c,
                                input bit ms);
    int cc;
    cc = (c > 99) ? 99 : c;
    exp_q.delete();
    exp_q.push_back(8'(48 + h / 10));
    exp_q.push_back(8'(48 + h % 10));
    exp_q.push_back(8'h3a);
    exp_q.push_back(8'(48 + m / 10));
    exp_q.push_back(8'(48 + m % 10));
    exp_q.push_back(8'h3a);
    exp_q.push_back(8'(48 + s / 10));
    exp_q.push_back(8'(48 + s % 10));
    if (ms) begin
      exp_q.push_back(8'h2e);
      exp_q.push_back(8'(48 + cc / 10));
      exp_q.push_back(8'(48 + cc % 10));
    end
    exp_q.push_back(8'h0d);
    exp_q.push_back(8'h0a);
  endfunction

  task automatic cmp_frame(input string tag, input bit which);
    logic [7:0] got[$];
    logic [7:0] g;
    if (which) got = q1;
    else got = q0;
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got.size()) ? got[i] : 8'h00;
      check($sformatf("%s_byte%0d", tag, i), {24'h0, g}, {24'h0, exp_q[i]});
    end
  endtask

  task automatic set_time(input int h, input int m, input int s, input int c);
    hour = 5'(h);
    min  = 6'(m);
    sec  = 6'(s);
    msec = 7'(c);
  endtask

  // Pulse a request and run until completion; optional stall window, random
  // back-pressure, or input disturbance plus a second request mid-frame.
  task automatic run_frame(input bit which, input int stall_at, input int stall_len,
                           input bit rnd, input bit chg, output int offset);
    int start_cnt, stalled, n, sz;
    start_cnt = which ? done1_cnt : done0_cnt;
    if (which) q1.delete();
    else q0.delete();
    @(negedge clk);
    if (which) req1 = 1'b1;
    else req0 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    req0 = 1'b0;
    n = 0;
    stalled = 0;
    while (((which ? done1_cnt : done0_cnt) == start_cnt) && (n < 400)) begin
      sz = which ? q1.size() : q0.size();
      if (chg && n == 0) set_time(23, 59, 59, 99);
      if (chg && n == 5) req1 = 1'b1;
      if (chg && n == 6) req1 = 1'b0;
      if (rnd) full = 1'($urandom_range(0, 1));
      else if (stall_len > 0 && sz == stall_at && stalled < stall_len) begin
        full = 1'b1;
        stalled++;
      end else full = 1'b0;
      @(negedge clk);
      n++;
    end
    full = 1'b0;
    req1 = 1'b0;
    check("frame_timeout", 32'(n < 400), 32'd1);
    offset = which ? (done1_cyc - req1_cyc) : (done0_cyc - req0_cyc);
  endtask

  int off, n, base;

  initial begin
    rst  = 1'b0;
    req1 = 1'b0;
    req0 = 1'b0;
    full = 1'b0;
    set_time(0, 0, 0, 0);
    #3;
    check("rst_push", 32'(push1), 32'd0);
    check("rst_data", 32'(data1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Plain frame, no back-pressure.
    set_time(12, 34, 56, 78);
    build(12, 34, 56, 78, 1'b1);
    run_frame(1'b1, 0, 0, 1'b0, 1'b0, off);
    cmp_frame("plain", 1'b1);
    check("plain_latency", off, 32'd15);

    // Five stalled cycles once four bytes are out.
    run_frame(1'b1, 4, 5, 1'b0, 1'b0, off);
    cmp_frame("stall", 1'b1);
    check("stall_latency", off, 32'd20);

    // Inputs disturbed and a second request mid-frame.
    base = done1_cnt;
    run_frame(1'b1, 0, 0, 1'b0, 1'b1, off);
    cmp_frame("snap", 1'b1);
    repeat (20) @(negedge clk);
    check("snap_one_frame", done1_cnt - base, 32'd1);
    check("snap_no_extra", q1.size(), 32'd13);

    // No-centiseconds variant, then clamped centiseconds.
    set_time(0, 0, 0, 0);
    build(0, 0, 0, 0, 1'b0);
    run_frame(1'b0, 0, 0, 1'b0, 1'b0, off);
    cmp_frame("nomsec", 1'b0);
    check("nomsec_latency", off, 32'd12);
    set_time(0, 0, 0, 120);
    build(0, 0, 0, 120, 1'b1);
    run_frame(1'b1, 0, 0, 1'b0, 1'b0, off);
    cmp_frame("clamp", 1'b1);

    // Reset after the sixth byte.
    set_time(12, 34, 56, 78);
    base = done1_cnt;
    q1.delete();
    @(negedge clk);
    req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    n = 0;
    while (q1.size() < 6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b0;
    #1;
    check("arst_push", 32'(push1), 32'd0);
    check("arst_data", 32'(data1), 32'd0);
    check("arst_busy", 32'(busy1), 32'd0);
    check("arst_done", 32'(done1), 32'd0);
    repeat (3) @(negedge clk);
    check("arst_bytes", q1.size(), 32'd6);
    check("arst_no_done", done1_cnt - base, 32'd0);
    rst = 1'b1;
    build(12, 34, 56, 78, 1'b1);
    run_frame(1'b1, 0, 0, 1'b0, 1'b0, off);
    cmp_frame("after_rst", 1'b1);

    // Random legal times under random back-pressure.
    base = done1_cnt;
    for (int f = 0; f < 20; f++) begin
      int h, m, s, c;
      h = $urandom_range(0, 23);
      m = $urandom_range(0, 59);
      s = $urandom_range(0, 59);
      c = $urandom_range(0, 99);
      set_time(h, m, s, c);
      build(h, m, s, c, 1'b1);
      run_frame(1'b1, 0, 0, 1'b1, 1'b0, off);
      cmp_frame($sformatf("rand%0d", f), 1'b1);
    end
    check("rand_done_count", done1_cnt - base, 32'd20);
    check("push_while_full", bad_push, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
